// File: rtl/clk_monitor.sv
// clk_monitor: measures the period of a slow asynchronous clock in clk_in cycles
// Ports:
//   clk_in        system clock, all logic on its rising edge
//   rst_n         asynchronous reset, active low
//   sig_in        monitored slow clock, asynchronous to clk_in
//   enable        1 = monitoring active, 0 = forced idle
//   edge_pulse    one-cycle pulse per synchronized rising edge of sig_in
//   period        last measured period in clk_in cycles, held between updates
//   period_valid  one-cycle pulse when period is updated
//   locked        period stable within tolerance for lock_count periods
//   stuck         no rising edge seen for twice the expected period
module clk_monitor #(
  parameter int input_clk_frequency = 1000000,
  parameter int expected_frequency  = 1,
  parameter int tolerance           = 1,
  parameter int lock_count          = 4,
  parameter int cnt_width           = 22
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 enable,
  output logic                 edge_pulse,
  output logic [cnt_width-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 stuck
);
  localparam int EXP_PERIOD = input_clk_frequency / expected_frequency;
  localparam int TIMEOUT    = 2 * EXP_PERIOD;
  localparam int SW         = $clog2(lock_count + 1);
  localparam logic [cnt_width-1:0] LO_W    = EXP_PERIOD > tolerance ? cnt_width'(EXP_PERIOD - tolerance) : '0;
  localparam logic [cnt_width-1:0] HI_W    = cnt_width'(EXP_PERIOD + tolerance);
  localparam logic [cnt_width-1:0] TO_LAST = cnt_width'(TIMEOUT - 1);
  localparam logic [SW-1:0]        LC_W    = SW'(lock_count);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic                 edge_pulse_q, edge_pulse_d;
  logic                 period_valid_q, period_valid_d;
  logic                 locked_q, locked_d, stuck_q, stuck_d;
  logic [cnt_width-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic                 rise, in_tol;
  logic [cnt_width-1:0] meas;

  assign rise   = s2_q & ~prev_q;
  assign meas   = cnt_q + 1'b1;
  assign in_tol = meas >= LO_W && meas <= HI_W;

  always_comb begin
    s1_d           = sig_in;
    s2_d           = s1_q;
    prev_d         = s2_q;
    edge_pulse_d   = rise;
    period_valid_d = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    streak_d       = streak_q;
    locked_d       = locked_q;
    stuck_d        = stuck_q;
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      streak_d = '0;
      locked_d = 1'b0;
      stuck_d  = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = ARM;
    end else if (rise) begin
      // a rise always restarts the count; only a rise seen while measuring closes a period
      state_d = MEASURE;
      cnt_d   = '0;
      stuck_d = 1'b0;
      if (state_q == MEASURE) begin
        period_d       = meas;
        period_valid_d = 1'b1;
        streak_d       = !in_tol ? '0 : streak_q == LC_W ? streak_q : streak_q + SW'(1);
        locked_d       = in_tol && streak_d == LC_W;
      end
    end else if (cnt_q == TO_LAST) begin
      state_d  = ARM;
      cnt_d    = '0;
      stuck_d  = 1'b1;
      locked_d = 1'b0;
      streak_d = '0;
    end else begin
      cnt_d = meas;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      prev_q         <= 1'b0;
      edge_pulse_q   <= 1'b0;
      period_valid_q <= 1'b0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      streak_q       <= '0;
      locked_q       <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      prev_q         <= prev_d;
      edge_pulse_q   <= edge_pulse_d;
      period_valid_q <= period_valid_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      streak_q       <= streak_d;
      locked_q       <= locked_d;
      stuck_q        <= stuck_d;
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stuck        = stuck_q;
endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed self-checking bench for clk_monitor (EXP_PERIOD=10, TIMEOUT=20)
module tb_clk_monitor;
  logic        clk_in = 1'b0, rst_n = 1'b0, sig_in = 1'b0, enable = 1'b0;
  logic        edge_pulse, period_valid, locked, stuck;
  logic [21:0] period;
  int          errors = 0, checks = 0;
  int          pv_n = 0, ep_n = 0, cyc = 0, ep_cyc = 0;
  logic [21:0] pv_per = '0;
  logic        pv_lock = 1'b0;

  clk_monitor #(
    .input_clk_frequency(100),
    .expected_frequency(10),
    .tolerance(1),
    .lock_count(4),
    .cnt_width(22)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .enable(enable),
    .edge_pulse(edge_pulse),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .stuck(stuck)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    if (period_valid) begin
      pv_n++;
      pv_per  = period;
      pv_lock = locked;
    end
    if (edge_pulse) begin
      ep_n++;
      ep_cyc = cyc;
    end
  endtask

  task automatic wave(input int p);
    sig_in = 1'b1;
    repeat (p / 2) step();
    sig_in = 1'b0;
    repeat (p - p / 2) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    checks++;
    if ({edge_pulse, period_valid, locked, stuck} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {edge_pulse, period_valid, locked, stuck});
    end
    checks++;
    if (period !== 22'd0) begin
      errors++;
      $display("FAIL reset_period: got %0d expected 0", period);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lock_acquire();
    enable = 1'b1;
    pv_n = 0;
    ep_n = 0;
    repeat (2) step();
    repeat (4) wave(10);
    checks++;
    if (pv_n != 3) begin
      errors++;
      $display("FAIL acquire_pv_count: got %0d expected 3", pv_n);
    end
    checks++;
    if (pv_per !== 22'd10) begin
      errors++;
      $display("FAIL acquire_period: got %0d expected 10", pv_per);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL acquire_early_lock: got %b expected 0", locked);
    end
    wave(10);
    checks++;
    if (pv_n != 4) begin
      errors++;
      $display("FAIL acquire_pv_count4: got %0d expected 4", pv_n);
    end
    checks++;
    if (pv_lock !== 1'b1) begin
      errors++;
      $display("FAIL acquire_lock_on_4th: got %b expected 1", pv_lock);
    end
    checks++;
    if (ep_n != 5) begin
      errors++;
      $display("FAIL acquire_edges: got %0d expected 5", ep_n);
    end
  endtask

  task automatic test_tolerance();
    int lens[8]    = '{9, 11, 8, 10, 10, 10, 10, 10};
    int exp_per[8] = '{10, 9, 11, 8, 10, 10, 10, 10};
    int exp_lk[8]  = '{1, 1, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      int n0 = pv_n;
      wave(lens[i]);
      checks++;
      if (pv_n != n0 + 1 || pv_per !== 22'(exp_per[i]) || pv_lock !== exp_lk[i][0]) begin
        errors++;
        $display("FAIL tolerance_%0d: got pv=%0d period=%0d locked=%b expected pv=1 period=%0d locked=%0d",
                 i, pv_n - n0, pv_per, pv_lock, exp_per[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_stuck();
    int n0;
    repeat (12) step();
    checks++;
    if (stuck !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL stuck_early: got stuck=%b locked=%b expected stuck=0 locked=1", stuck, locked);
    end
    step();
    checks++;
    if (stuck !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL stuck_timeout: got stuck=%b locked=%b expected stuck=1 locked=0", stuck, locked);
    end
    repeat (25) step();
    checks++;
    if (stuck !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: got %b expected 1", stuck);
    end
    n0 = pv_n;
    wave(10);
    checks++;
    if (pv_n != n0 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_clear: got pv=%0d stuck=%b expected pv=0 stuck=0", pv_n - n0, stuck);
    end
    wave(10);
    checks++;
    if (pv_n != n0 + 1 || pv_per !== 22'd10 || pv_lock !== 1'b0) begin
      errors++;
      $display("FAIL stuck_resume: got pv=%0d period=%0d locked=%b expected pv=1 period=10 locked=0",
               pv_n - n0, pv_per, pv_lock);
    end
  endtask

  task automatic test_enable();
    int n0;
    repeat (3) wave(10);
    checks++;
    if (pv_lock !== 1'b1) begin
      errors++;
      $display("FAIL enable_relock: got %b expected 1", pv_lock);
    end
    enable = 1'b0;
    step();
    checks++;
    if (locked !== 1'b0 || stuck !== 1'b0 || period !== 22'd10) begin
      errors++;
      $display("FAIL enable_off: got locked=%b stuck=%b period=%0d expected 0 0 10", locked, stuck, period);
    end
    n0 = pv_n;
    repeat (2) step();
    enable = 1'b1;
    wave(10);
    checks++;
    if (pv_n != n0) begin
      errors++;
      $display("FAIL enable_first_rise: got pv=%0d expected 0", pv_n - n0);
    end
    wave(10);
    checks++;
    if (pv_n != n0 + 1 || pv_per !== 22'd10) begin
      errors++;
      $display("FAIL enable_resume: got pv=%0d period=%0d expected pv=1 period=10", pv_n - n0, pv_per);
    end
  endtask

  task automatic test_async_reset();
    sig_in = 1'b1;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({edge_pulse, period_valid, locked, stuck} !== 4'b0 || period !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b period=%0d expected 0000 0",
               {edge_pulse, period_valid, locked, stuck}, period);
    end
    sig_in = 1'b0;
    #2;
    rst_n = 1'b1;
    test_lock_acquire();
  endtask

  task automatic test_glitch();
    int start;
    ep_n = 0;
    start = cyc;
    sig_in = 1'b1;
    step();
    sig_in = 1'b0;
    repeat (6) step();
    checks++;
    if (ep_n != 1) begin
      errors++;
      $display("FAIL glitch_count: got %0d expected 1", ep_n);
    end
    checks++;
    if (ep_cyc - start != 3) begin
      errors++;
      $display("FAIL glitch_latency: got %0d expected 3", ep_cyc - start);
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_tolerance();
    test_stuck();
    test_enable();
    test_async_reset();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
